instr_fetch: RTL



---
 rtl/mips_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/instr_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-1 core definitions: widths, fetch FSM encoding, queue entry
// layout and the opcode constants the main decoder keys on.
package mips_pkg;

   localparam int ADDR_W      = 32;
   localparam int FETCH_DEPTH = 2;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       instr;
   } fetch_entry_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order {pc, instr} queue; slot 0 is always the registered head
// so the decoder sees stable outputs until the entry is popped.
module fetch_fifo
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t ent0_r, ent1_r, ent0_s, ent1_s;
   logic [1:0]   count_r, count_s;

   // Next contents of the two slots; flush wins over any push or pop.
   always_comb begin
      ent0_s  = ent0_r;
      ent1_s  = ent1_r;
      count_s = count_r;
      if (flush) begin
         count_s = 2'd0;
      end else begin
         case (count_r)
            2'd0: begin
               if (push) begin
                  ent0_s  = push_data;
                  count_s = 2'd1;
               end else begin
                  count_s = 2'd0;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  ent0_s = push_data;
               end else if (push) begin
                  ent1_s  = push_data;
                  count_s = 2'd2;
               end else if (pop) begin
                  count_s = 2'd0;
               end else begin
                  count_s = 2'd1;
               end
            end
            2'd2: begin
               if (pop) begin
                  ent0_s = ent1_r;
                  if (push) begin
                     ent1_s = push_data;
                  end else begin
                     count_s = 2'd1;
                  end
               end else begin
                  count_s = 2'd2;
               end
            end
            default: count_s = 2'd0;
         endcase
      end
   end

   // Queue storage and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_r  <= '0;
         ent1_r  <= '0;
         count_r <= 2'd0;
      end else begin
         ent0_r  <= ent0_s;
         ent1_r  <= ent1_s;
         count_r <= count_s;
      end
   end

   assign count = count_r;
   assign head  = ent0_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the PC, issues in-order word reads to imem and
// hands {pc, instr} to the decoder; a redirect flushes and drops stale responses.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                DEPTH    = FETCH_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [31:0]       imem_rdata_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i
);

   fetch_state_e      state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic [1:0]        outst_r, outst_s, discard_r, discard_s;
   logic [ADDR_W-1:0] tag_r [2];
   logic [ADDR_W-1:0] tag_s [2];
   logic              req_r, req_s;
   logic [1:0]        count_s, count_next_s;
   logic [2:0]        credit_s;
   logic              gnt_s, rsp_s, drop_s, push_s, pop_s, valid_s, tag_idx_s;
   fetch_entry_t      push_data_s, head_s;
   logic [1:0]        unused_bits;

   assign unused_bits = redirect_pc_i[1:0];

   assign gnt_s       = req_r & imem_gnt_i;
   assign rsp_s       = imem_rvalid_i & (outst_r != 2'd0);
   assign drop_s      = rsp_s & (discard_r != 2'd0);
   assign push_s      = rsp_s & ~drop_s & ~redirect_i;
   assign valid_s     = (count_s != 2'd0);
   assign pop_s       = valid_s & instr_ready_i;
   assign push_data_s = '{pc: tag_r[0], instr: imem_rdata_i};

   // A request is only raised with outstanding <= 1, so the new tag lands at
   // index (outstanding - retiring response), which is 0 or 1.
   assign tag_idx_s = outst_r[0] & ~rsp_s;

   // Datapath next state: PC, outstanding/discard accounting and request tags.
   always_comb begin
      outst_s  = outst_r - {1'b0, rsp_s} + {1'b0, gnt_s};
      tag_s[0] = (gnt_s && !tag_idx_s) ? pc_r : (rsp_s ? tag_r[1] : tag_r[0]);
      tag_s[1] = (gnt_s &&  tag_idx_s) ? pc_r : tag_r[1];
      if (redirect_i) begin
         pc_s         = {redirect_pc_i[ADDR_W-1:2], 2'b00};
         discard_s    = outst_s;
         count_next_s = 2'd0;
      end else begin
         pc_s         = gnt_s ? (pc_r + 32'd4) : pc_r;
         discard_s    = discard_r - {1'b0, drop_s};
         count_next_s = count_s + {1'b0, push_s} - {1'b0, pop_s};
      end
   end

   // FSM next state and the registered request decision for the next cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_BOOT:  state_s = S_FETCH;
         S_FETCH: state_s = S_FETCH;
         S_FLUSH: state_s = (discard_s == 2'd0) ? S_FETCH : S_FLUSH;
         default: state_s = S_BOOT;
      endcase
      if (redirect_i) begin
         state_s = (discard_s != 2'd0) ? S_FLUSH : S_FETCH;
      end else begin
         state_s = state_s;
      end
      credit_s = {1'b0, outst_s} + {1'b0, count_next_s};
      req_s    = (state_s == S_FETCH) && (credit_s < 3'(DEPTH));
   end

   // Fetch state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r   <= S_BOOT;
         pc_r      <= {RESET_PC[ADDR_W-1:2], 2'b00};
         outst_r   <= 2'd0;
         discard_r <= 2'd0;
         tag_r     <= '{default: '0};
         req_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         outst_r   <= outst_s;
         discard_r <= discard_s;
         tag_r     <= tag_s;
         req_r     <= req_s;
      end
   end

   fetch_fifo u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .flush     (redirect_i),
      .count     (count_s),
      .head      (head_s)
   );

   assign imem_req_o    = req_r;
   assign imem_addr_o   = pc_r;
   assign instr_valid_o = valid_s;
   assign instr_o       = head_s.instr;
   assign instr_pc_o    = head_s.pc;

endmodule
